// File: rtl/aes_stream.sv
// Stream wrapper around a block cipher: collects NW input words into one block, starts the cipher,
// then returns the NW result words with valid/ready handshaking. NW must be a power of two (>= 2).
module aes_stream #(
  parameter int NW      = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_data,
  output logic [4*NW-1:0][7:0]   Data_out,
  output logic                   Enable_out,
  input  logic [4*NW-1:0][7:0]   Data_in,
  input  logic                   Ready_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic                   busy,
  output logic                   err
);

  localparam int CW = $clog2(NW);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {LOAD, START, WAIT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            err_q, err_d;
  logic [31:0]     inBuf_q  [NW];
  logic [31:0]     inBuf_d  [NW];
  logic [31:0]     resBuf_q [NW];
  logic [31:0]     resBuf_d [NW];
  logic [31:0]     capWord  [NW];

  // Word w occupies bytes 4w..4w+3 of the cipher block, most significant byte first.
  for (genvar w = 0; w < NW; w++) begin : g_word
    for (genvar b = 0; b < 4; b++) begin : g_byte
      assign Data_out[4*w+b] = inBuf_q[w][31-8*b -: 8];
    end
    assign capWord[w] = {Data_in[4*w], Data_in[4*w+1], Data_in[4*w+2], Data_in[4*w+3]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
      for (int w = 0; w < NW; w++) begin
        inBuf_q[w]  <= '0;
        resBuf_q[w] <= '0;
      end
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rcnt_q   <= rcnt_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      inBuf_q  <= inBuf_d;
      resBuf_q <= resBuf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    tcnt_d     = tcnt_q;
    err_d      = err_q;
    inBuf_d    = inBuf_q;
    resBuf_d   = resBuf_q;
    in_ready   = 1'b0;
    Enable_out = 1'b0;
    out_valid  = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inBuf_d[wcnt_q] = in_data;
          if (wcnt_q == CW'(NW - 1)) begin
            wcnt_d  = '0;
            state_d = START;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      START: begin
        Enable_out = 1'b1;
        tcnt_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        // A response in the same cycle as the final timeout tick still wins.
        if (Ready_in) begin
          resBuf_d = capWord;
          state_d  = DRAIN;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
          if (tcnt_d == TW'(TIMEOUT)) begin
            err_d   = 1'b1;
            wcnt_d  = '0;
            state_d = LOAD;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          if (rcnt_q == CW'(NW - 1)) begin
            rcnt_d  = '0;
            state_d = LOAD;
          end else begin
            rcnt_d = rcnt_q + CW'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign out_data = resBuf_q[rcnt_q];
  assign busy     = (state_q != LOAD);
  assign err      = err_q;

endmodule

// File: tb/tb_aes_stream.sv
// Scoreboard bench for aes_stream: a stub cipher answers each Enable pulse, expected result words
// are queued when a block is submitted and a monitor pops them as the DUT hands words out.
module tb_aes_stream;

  localparam int NW = 4;
  localparam int TO = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic                inValid;
  logic                inReady;
  logic [31:0]         inData;
  logic [4*NW-1:0][7:0] dataOut;
  logic                enableOut;
  logic [4*NW-1:0][7:0] dataIn;
  logic                readyIn;
  logic                outValid;
  logic                outReady;
  logic [31:0]         outData;
  logic                busy;
  logic                err;

  int          checks = 0;
  int          failures = 0;
  int          enableCount = 0;
  logic [31:0] expQ [$];
  int          stubMode = 0;
  bit          glitchStart = 0;
  bit          spuriousReq = 0;
  int          readyMode = 0;
  logic [15:0][7:0] fipsPt;
  logic [15:0][7:0] fipsCt;

  always #5 clk = ~clk;

  aes_stream #(.NW(NW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData),
    .Data_out(dataOut), .Enable_out(enableOut),
    .Data_in(dataIn), .Ready_in(readyIn),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .busy(busy), .err(err)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [3:0][31:0] makeBlock(input logic [31:0] a, b, c, d);
    logic [3:0][31:0] w;
    w[0] = a; w[1] = b; w[2] = c; w[3] = d;
    return w;
  endfunction

  // Block byte i is byte (i mod 4) of word i/4, counting from the most significant end.
  function automatic logic [15:0][7:0] wordsToBytes(input logic [3:0][31:0] w);
    logic [15:0][7:0] b;
    for (int i = 0; i < 16; i++) b[i] = 8'(w[i/4] >> (24 - 8*(i%4)));
    return b;
  endfunction

  // Cipher stand-in: the FIPS-197 vector is answered exactly, anything else by a fixed byte scramble.
  function automatic logic [15:0][7:0] cipherModel(input logic [15:0][7:0] pt);
    logic [15:0][7:0] ct;
    if (pt == fipsPt) return fipsCt;
    for (int i = 0; i < 16; i++) ct[i] = pt[(i*7 + 5) % 16] ^ 8'(8'h5a + 3*i);
    return ct;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [31:0] w);
    int n;
    n = 0;
    inValid = 1'b1;
    inData  = w;
    while (1) begin
      @(negedge clk);
      if (inReady) break;
      n++;
      if (n > 3000) begin
        failures++;
        $display("[TB] FAIL inputStall: in_ready got 0, expected 1");
        $fatal(1, "[TB] input side stalled");
      end
    end
    tick();
    inValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [3:0][31:0] blk, input int gap, input int nWords, input bit expectOut);
    logic [15:0][7:0] ct;
    for (int i = 0; i < nWords; i++) begin
      sendWord(blk[i]);
      if (i < nWords - 1) repeat (gap) tick();
    end
    if (nWords == NW) begin
      @(negedge clk);
      checkOutput("enableLatency", enableOut, 1'b1);
      if (expectOut) begin
        ct = cipherModel(wordsToBytes(blk));
        for (int i = 0; i < NW; i++) expQ.push_back({ct[4*i], ct[4*i+1], ct[4*i+2], ct[4*i+3]});
      end
      tick();
    end
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while ((expQ.size() != 0 || outValid || busy) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      failures++;
      $display("[TB] FAIL drainTimeout: %0d words still pending, expected 0", expQ.size());
    end
    tick();
  endtask

  function automatic logic [3:0][31:0] randBlock();
    return makeBlock($urandom(), $urandom(), $urandom(), $urandom());
  endfunction

  // Stub cipher: answers Enable after 1..6 cycles, or never when stubMode is 1.
  initial begin
    int pending;
    bit armed;
    logic [15:0][7:0] blk;
    pending = -1;
    armed   = 0;
    readyIn = 1'b0;
    dataIn  = '0;
    forever begin
      @(negedge clk);
      if (armed) begin
        checkOutput("readyToValid", outValid, 1'b1);
        armed = 0;
      end
      readyIn = 1'b0;
      if (rst) begin
        pending = -1;
      end else if (spuriousReq) begin
        readyIn = 1'b1;
        dataIn  = {$urandom(), $urandom(), $urandom(), $urandom()};
        spuriousReq = 0;
      end else if (enableOut) begin
        blk     = dataOut;
        pending = (stubMode == 1) ? -1 : int'($urandom_range(1, 6));
        if (glitchStart) begin
          readyIn = 1'b1;
          dataIn  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
      end else if (pending > 0) begin
        pending--;
        if (pending == 0) begin
          readyIn = 1'b1;
          dataIn  = cipherModel(blk);
          armed   = 1;
          pending = -1;
        end
      end
    end
  end

  // Downstream: always ready, fixed 1-0-0-1 pattern, or random.
  initial begin
    int ph;
    ph = 0;
    outReady = 1'b1;
    forever begin
      tick();
      case (readyMode)
        1:       outReady = (ph % 4 == 0) || (ph % 4 == 3);
        2:       outReady = 1'($urandom_range(0, 1));
        default: outReady = 1'b1;
      endcase
      ph++;
    end
  end

  // Monitor: scoreboard pops, hold-under-backpressure and single-cycle Enable checks.
  initial begin
    bit prevHold;
    bit prevEn;
    logic [31:0] heldData;
    logic [31:0] exp;
    prevHold = 0;
    prevEn   = 0;
    heldData = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevHold = 0;
        prevEn   = 0;
      end else begin
        if (enableOut) begin
          enableCount++;
          checkOutput("enableOneCycle", prevEn, 1'b0);
        end
        prevEn = enableOut;
        if (prevHold) begin
          checkOutput("holdValid", outValid, 1'b1);
          if (outValid) checkOutput("holdData", outData, heldData);
        end
        prevHold = 0;
        if (outValid) begin
          checkOutput("inReadyInDrain", inReady, 1'b0);
          if (outReady) begin
            if (expQ.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpectedWord: got %h, expected no output", outData);
            end else begin
              exp = expQ.pop_front();
              checkOutput("outWord", outData, exp);
            end
          end else begin
            prevHold = 1;
            heldData = outData;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int en0;
    fipsPt = wordsToBytes(makeBlock(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff));
    fipsCt = wordsToBytes(makeBlock(32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a));
    rst     = 1'b1;
    inValid = 1'b0;
    inData  = '0;
    repeat (2) tick();
    @(negedge clk);
    checkOutput("rstInReady", inReady, 1'b1);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstOutValid", outValid, 1'b0);
    checkOutput("rstEnable", enableOut, 1'b0);
    checkOutput("rstErr", err, 1'b0);
    checkOutput("rstDataOut", dataOut, 128'h0);
    checkOutput("rstResult", outData, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Known-answer block: exactly one Enable pulse.
    en0 = enableCount;
    applyStimulus(makeBlock(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff), 0, NW, 1);
    waitDrain();
    checkOutput("fipsEnableCount", 32'(enableCount - en0), 32'd1);

    readyMode = 1;
    applyStimulus(randBlock(), 0, NW, 1);
    waitDrain();
    readyMode = 0;

    // Gaps between words, then a second block queued while the first is still in flight.
    applyStimulus(randBlock(), 3, NW, 1);
    applyStimulus(randBlock(), 0, NW, 1);
    applyStimulus(randBlock(), 0, NW, 1);
    waitDrain();

    spuriousReq = 1;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      checkOutput("spuriousValid", outValid, 1'b0);
      checkOutput("spuriousBusy", busy, 1'b0);
    end
    tick();

    glitchStart = 1;
    applyStimulus(randBlock(), 0, NW, 1);
    glitchStart = 0;
    waitDrain();

    // Cipher never answers: abort after TO wait cycles with the sticky error set.
    stubMode = 1;
    applyStimulus(randBlock(), 0, NW, 0);
    for (int k = 1; k <= TO + 1; k++) begin
      @(negedge clk);
      if (k == TO) begin
        checkOutput("timeoutErrEarly", err, 1'b0);
        checkOutput("timeoutBusyEarly", busy, 1'b1);
      end
      if (k == TO + 1) begin
        checkOutput("timeoutErr", err, 1'b1);
        checkOutput("timeoutLoad", inReady, 1'b1);
        checkOutput("timeoutNoValid", outValid, 1'b0);
      end
    end
    tick();
    stubMode = 0;
    repeat (3) tick();
    applyStimulus(randBlock(), 1, NW, 1);
    waitDrain();
    checkOutput("errSticky", err, 1'b1);

    // Reset after two words: the partial block and the error flag must vanish.
    applyStimulus(randBlock(), 0, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    en0 = enableCount;
    repeat (4) begin
      @(negedge clk);
      checkOutput("postRstValid", outValid, 1'b0);
    end
    checkOutput("postRstErr", err, 1'b0);
    checkOutput("postRstEnable", 32'(enableCount - en0), 32'd0);
    tick();
    applyStimulus(makeBlock(32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f), 0, NW, 1);
    waitDrain();

    readyMode = 2;
    for (int n = 0; n < 6; n++) applyStimulus(randBlock(), int'($urandom_range(0, 2)), NW, 1);
    waitDrain();
    readyMode = 0;

    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_stream.md
AES_STREAM -- requirements
Module: aes_stream

Interface
REQ-001 SHALL have parameter NW, default 4: 32-bit words per block (Nb from aes_const; 4*NW bytes).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before the block aborts.
REQ-003 SHALL have port clk  input  1: single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1: upstream word valid.
REQ-006 SHALL have port in_ready  output  1: block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  32: plaintext word; bits [31:24] map to byte 4*w, [7:0] to byte 4*w+3.
REQ-008 SHALL have port Data_out  output  8 x 4*NW: assembled block to the cipher's Data_in.
REQ-009 SHALL have port Enable_out  output  1: one-cycle start pulse to the cipher's Enable.
REQ-010 SHALL have port Data_in  input  8 x 4*NW: result from the cipher's Data_out.
REQ-011 SHALL have port Ready_in  input  1: cipher Ready_out; result is valid in that cycle.
REQ-012 SHALL have port out_valid  output  1: result word valid.
REQ-013 SHALL have port out_ready  input  1: downstream accepts out_data.
REQ-014 SHALL have port out_data  output  32: result word, same byte order as in_data.
REQ-015 SHALL have port busy  output  1: high in every state except LOAD.
REQ-016 SHALL have port err  output  1: sticky timeout flag.

Function
REQ-017 SHALL implement FSM states LOAD, START, WAIT, DRAIN.
REQ-018 LOAD: in_ready=1; on in_valid&in_ready, store the word at index wcnt and increment wcnt; when word NW-1 is accepted, wcnt SHALL clear and the state SHALL go to START.
REQ-019 START: Enable_out=1 for exactly this one cycle; Data_out stable; next state WAIT; the timeout counter SHALL clear.
REQ-020 WAIT: Data_out SHALL stay stable; on Ready_in=1, capture Data_in into the result buffer and go to DRAIN.
REQ-021 WAIT: the timeout counter SHALL increment each cycle without Ready_in; when it reaches TIMEOUT, err SHALL be set, wcnt SHALL clear, and the state SHALL go to LOAD with no output words.
REQ-022 DRAIN: out_valid=1 and out_data=result word rcnt; rcnt SHALL increment on out_valid&out_ready.
REQ-023 DRAIN: after word NW-1 is accepted, rcnt SHALL clear and the state SHALL go to LOAD.
REQ-024 While out_ready=0, out_data SHALL hold and out_valid SHALL stay high.
REQ-025 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored and no word SHALL be lost.
REQ-026 Ready_in outside WAIT SHALL be ignored; Ready_in in the START cycle SHALL NOT be captured.
REQ-027 Latency: last input word accepted at cycle t -> Enable_out high at t+1.
REQ-028 Latency: Ready_in at cycle u in WAIT -> out_valid high with word 0 at u+1.
REQ-029 Best case from the first accepted input word to the last output word SHALL be NW+1+cipher latency+NW cycles.
REQ-030 Counters wcnt and rcnt SHALL be log2(NW) bits wide; the timeout counter SHALL be wide enough for TIMEOUT.
REQ-031 Buffers SHALL NOT be shared, so a WAIT abort leaves the previous result buffer unchanged.
REQ-032 err SHALL clear only on reset.

Reset
REQ-033 With rst=1 at a posedge, the next cycle SHALL have state LOAD, wcnt=rcnt=timeout=0, Enable_out=0, out_valid=0, err=0, busy=0, in_ready=1.
REQ-034 Reset SHALL clear Data_out and the result buffer to all zero.
REQ-035 Reset mid-block (any state) SHALL discard partial input and output; no Enable_out pulse and no out_valid SHALL follow the reset.

Verification
REQ-036 Bench SHALL cover FIPS-197 AES-128: key 000102..0f; words 00112233, 44556677, 8899aabb, ccddeeff -> one Enable_out pulse, then out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
REQ-037 Bench SHALL cover backpressure: out_ready toggling 1-0-0-1 -> each word held until accepted, 4 words in order, none duplicated.
REQ-038 Bench SHALL cover input gaps: in_valid low 3 cycles between words -> block assembles correctly; in_valid held high during WAIT -> in_ready=0, extra word accepted only after DRAIN completes.
REQ-039 Bench SHALL cover timeout: stub cipher never asserts Ready_in, TIMEOUT=8 -> err=1 at cycle 9 of WAIT, state LOAD, no out_valid.
REQ-040 Bench SHALL cover reset: rst asserted after 2 input words, then block 0..0f submitted -> output equals a fresh encryption of block 0..0f only.
REQ-041 Bench SHALL cover a spurious Ready_in pulse in LOAD -> ignored, out_valid stays 0.
